// File: rtl/reg_file_gen.sv
// Parametrised register file: DEPTH x WIDTH registers, masked multi-select update,
// two combinational read ports, sticky per-register overflow flags, event pulse.
// Optional macro REGFILE_SAT_EN: inc/dec saturate instead of wrapping.

module reg_file_gen_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sel_i,
  input  logic [2:0]       fun_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] data_o,
  output logic             ovf_o,
  output logic             evt_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    data_d = data_q;
    ovf_d  = ovf_q;
    evt_o  = 1'b0;
    if (sel_i) begin
      case (fun_i)
        3'b000: begin
          data_d = data_q - 1'b1;
          if (data_q == '0) begin
            evt_o = 1'b1;
`ifdef REGFILE_SAT_EN
            data_d = data_q;
`endif
          end
        end
        3'b001: begin
          data_d = data_q + 1'b1;
          if (data_q == '1) begin
            evt_o = 1'b1;
`ifdef REGFILE_SAT_EN
            data_d = data_q;
`endif
          end
        end
        3'b010: data_d = din_i;
        3'b011: data_d = '0;
        3'b100: data_d = {data_q[WIDTH-2:0], 1'b0};
        3'b101: data_d = {1'b0, data_q[WIDTH-1:1]};
        3'b110: data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        default: data_d = data_q;
      endcase
      if (evt_o) ovf_d = 1'b1;
      // load/clear is ordered last so a clear beats a same-edge set
      if (fun_i == 3'b010 || fun_i == 3'b011) ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign data_o = data_q;
  assign ovf_o  = ovf_q;
endmodule

module reg_file_gen #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [DEPTH-1:0] RegSel,
  input  logic [SEL_W-1:0] OutASel,
  input  logic [SEL_W-1:0] OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [DEPTH-1:0] OvfFlags,
  output logic             Evt
);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            ovf_evt;
  logic                        evt_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    reg_file_gen_cell #(.WIDTH(WIDTH)) u_cell (
      .clk_i  (CLK),
      .rst_i  (Reset),
      .sel_i  (RegSel[k]),
      .fun_i  (FunSel),
      .din_i  (I),
      .data_o (regs[k]),
      .ovf_o  (OvfFlags[k]),
      .evt_o  (ovf_evt[k])
    );
  end

  always_ff @(posedge CLK) begin
    if (Reset) evt_q <= 1'b0;
    else       evt_q <= |ovf_evt;
  end
  assign Evt = evt_q;

  // select by compare so out-of-range selects (non-power-of-two DEPTH) read zero
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (OutASel == SEL_W'(k)) OutA = regs[k];
      if (OutBSel == SEL_W'(k)) OutB = regs[k];
    end
  end
endmodule

// File: tb/tb_reg_file_gen.sv
// Randomised + directed bench for reg_file_gen (WIDTH=8, DEPTH=4) against an
// arithmetic reference model of the register file.

module tb_reg_file_gen;
  localparam int W = 8;
  localparam int D = 4;
  localparam int MAXV = 255;

  logic         CLK = 1'b0;
  logic         Reset;
  logic [W-1:0] I;
  logic [2:0]   FunSel;
  logic [D-1:0] RegSel;
  logic [1:0]   OutASel, OutBSel;
  logic [W-1:0] OutA, OutB;
  logic [D-1:0] OvfFlags;
  logic         Evt;

  reg_file_gen #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
    .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB),
    .OvfFlags(OvfFlags), .Evt(Evt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int m_reg[D];
  bit m_ovf[D];
  bit m_evt;

`ifdef REGFILE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [D-1:0] eo;
    for (int k = 0; k < D; k++) begin
      OutASel = 2'(k);
      OutBSel = 2'(D-1-k);
      #1;
      chk($sformatf("OutA[%0d]", k), 32'(OutA), 32'(m_reg[k]));
      chk($sformatf("OutB[%0d]", D-1-k), 32'(OutB), 32'(m_reg[D-1-k]));
    end
    for (int k = 0; k < D; k++) eo[k] = m_ovf[k];
    chk("OvfFlags", 32'(OvfFlags), 32'(eo));
    chk("Evt", 32'(Evt), 32'(m_evt));
  endtask

  // apply one edge of stimulus; model next state from the function table
  task automatic drive(input bit rst, input int fs, input int rs, input int din);
    int  nreg[D];
    bit  novf[D];
    bit  nevt;
    Reset = rst; FunSel = 3'(fs); RegSel = 4'(rs); I = 8'(din);
    if (!rst) begin
      #1;
      chk("read-old", 32'(OutA), 32'(m_reg[OutASel]));
    end
    nevt = 0;
    for (int k = 0; k < D; k++) begin
      int v;
      bit o;
      v = m_reg[k]; o = 0;
      nreg[k] = v; novf[k] = m_ovf[k];
      if (rs[k]) begin
        case (fs)
          0: begin o = (v == 0);    nreg[k] = o ? (SAT ? 0 : MAXV) : v - 1; end
          1: begin o = (v == MAXV); nreg[k] = o ? (SAT ? MAXV : 0) : v + 1; end
          2: nreg[k] = din % 256;
          3: nreg[k] = 0;
          4: nreg[k] = (v * 2) % 256;
          5: nreg[k] = v / 2;
          6: nreg[k] = (v * 2) % 256 + v / 128;
          default: nreg[k] = v;
        endcase
        if (o) novf[k] = 1;
        if (fs == 2 || fs == 3) novf[k] = 0;
        nevt |= o;
      end
      if (rst) begin nreg[k] = 0; novf[k] = 0; end
    end
    if (rst) nevt = 0;
    @(posedge CLK);
    #1;
    m_reg = nreg; m_ovf = novf; m_evt = nevt;
    Reset = 1'b0;
    check_all();
  endtask

  initial begin
    int r0;
    Reset = 1'b1; I = '0; FunSel = 3'b111; RegSel = '0; OutASel = '0; OutBSel = '0;
    @(negedge CLK);
    drive(1, 7, 0, 0);
    drive(1, 7, 0, 0);

    // load all, read same value on both ports
    drive(0, 2, 4'b1111, 8'h80);
    OutASel = 2; OutBSel = 3; #1;
    chk("load-A2", 32'(OutA), 32'h80);
    chk("load-B3", 32'(OutB), 32'h80);

    // increment through all-ones
    drive(0, 2, 4'b0001, 8'hFE);
    drive(0, 1, 4'b0001, 0);
    OutASel = 0; #1; chk("inc1", 32'(OutA), 32'hFF); chk("inc1-evt", 32'(Evt), 0);
    drive(0, 1, 4'b0001, 0);
    OutASel = 0; #1; chk("inc2", 32'(OutA), SAT ? 32'hFF : 32'h00);
    chk("inc2-evt", 32'(Evt), 1); chk("inc2-ovf", 32'(OvfFlags[0]), 1);
    drive(0, 1, 4'b0001, 0);
    OutASel = 0; #1; chk("inc3", 32'(OutA), SAT ? 32'hFF : 32'h01);
    chk("inc3-evt", 32'(Evt), SAT ? 1 : 0);

    // shift/rotate on R1
    drive(0, 2, 4'b0010, 8'h81);
    drive(0, 4, 4'b0010, 0);
    OutASel = 1; #1; chk("shl", 32'(OutA), 32'h02);
    drive(0, 5, 4'b0010, 0);
    OutASel = 1; #1; chk("shr", 32'(OutA), 32'h01);
    drive(0, 2, 4'b0010, 8'h81);
    drive(0, 6, 4'b0010, 0);
    OutASel = 1; #1; chk("rol", 32'(OutA), 32'h03);

    // sticky flag on R2, then clear; then a no-op mask
    drive(0, 3, 4'b0100, 0);
    drive(0, 0, 4'b0100, 0);
    chk("dec0-ovf2", 32'(OvfFlags[2]), 1);
    drive(0, 4, 4'b0100, 0);
    chk("ovf-hold-shift", 32'(OvfFlags[2]), 1);
    drive(0, 3, 4'b0100, 0);
    chk("clr-ovf2", 32'(OvfFlags[2]), 0);
    drive(0, 2, 4'b0000, 8'h5A);
    chk("noop-evt", 32'(Evt), 0);

    // reset beats a same-edge overflowing increment
    drive(0, 2, 4'b1000, 8'hFF);
    drive(1, 1, 4'b1111, 0);
    chk("rst-ovf", 32'(OvfFlags), 0);
    chk("rst-evt", 32'(Evt), 0);

    // two registers, one overflows
    drive(0, 2, 4'b0010, 8'h05);
    drive(0, 0, 4'b0011, 0);
    OutASel = 0; OutBSel = 1; #1;
    chk("dual-R0", 32'(OutA), SAT ? 32'h00 : 32'hFF);
    chk("dual-R1", 32'(OutB), 32'h04);
    chk("dual-ovf", 32'(OvfFlags), 32'b0001);
    chk("dual-evt", 32'(Evt), 1);
    drive(0, 7, 4'b1111, 0);
    chk("evt-once", 32'(Evt), 0);

    // randomised run, biased toward wrap boundaries
    for (int n = 0; n < 400; n++) begin
      int d;
      case ($urandom_range(0, 5))
        0: d = 8'hFF;
        1: d = 8'h00;
        2: d = 8'h01;
        default: d = int'($urandom_range(0, 255));
      endcase
      drive(($urandom_range(0, 40) == 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 15)), d);
    end

    r0 = errors;
    $display("CHECKS %0d ERRORS %0d", checks, r0);
    $finish;
  end
endmodule
